log_capture: RTL and testbench

LOG_CAPTURE -- requirements
Module: log_capture

---
 rtl/log_capture.sv | 94 +++++++++
 tb/tb_log_capture.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/log_capture.sv
// log_capture: per-channel step counters logged into a RAM, one-shot or circular with post-trigger.
module log_capture #(
  parameter int NB_DATA     = 32,
  parameter int NB_ADDR     = 13,
  parameter int N_CH        = 4,
  parameter int NB_ENB_STEP = 4,
  parameter int NB_CH_SEL   = 2
) (
  input  logic                        clock,
  input  logic                        cpu_reset,
  input  logic                        i_run,
  input  logic                        i_stop,
  input  logic                        i_mode,
  input  logic [NB_CH_SEL-1:0]        i_ch_sel,
  input  logic [NB_ADDR-1:0]          i_post_cnt,
  input  logic [N_CH*NB_ENB_STEP-1:0] i_step_enb,
  input  logic [NB_ADDR-1:0]          i_rd_addr,
  output logic [NB_DATA-1:0]          o_rd_data,
  output logic                        o_busy,
  output logic                        o_full,
  output logic                        o_wrapped,
  output logic [NB_ADDR-1:0]          o_last_addr
);
  typedef enum logic [1:0] {IDLE, LOG, POST, DONE} state_t;
  state_t state, state_d;
  logic [NB_DATA-1:0] cnt [N_CH];
  logic [NB_DATA-1:0] mem [2**NB_ADDR];
  logic run_q, stop_q, run_edge, stop_edge, start, we, at_max, mode_l;
  logic [NB_CH_SEL-1:0] ch_l;
  logic [NB_ADDR-1:0] post_l, post_ctr, wr_addr;
  function automatic logic [NB_DATA-1:0] incr(input logic [NB_ENB_STEP-1:0] e);
    incr = '0;
    for (int k = NB_ENB_STEP - 1; k >= 0; k--)
      if (e[k]) incr = NB_DATA'(k + 1);
  endfunction
  assign run_edge  = i_run & ~run_q;
  assign stop_edge = i_stop & ~stop_q;
  assign at_max    = wr_addr == '1;
  assign we        = state == LOG || state == POST;
  assign o_busy    = we;
  assign o_full    = state == DONE;
  always_comb begin
    state_d = state;
    start   = 1'b0;
    case (state)
      IDLE, DONE: begin
        start   = run_edge;
        state_d = run_edge ? LOG : state;
      end
      LOG:  state_d = (mode_l & stop_edge) ? (post_l == '0 ? DONE : POST) : (!mode_l & at_max) ? DONE : LOG;
      POST: state_d = (post_ctr + NB_ADDR'(1) == post_l) ? DONE : POST;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (cpu_reset) begin
      state       <= IDLE;
      run_q       <= 1'b0;
      stop_q      <= 1'b0;
      wr_addr     <= '0;
      post_ctr    <= '0;
      o_wrapped   <= 1'b0;
      o_last_addr <= '0;
      mode_l      <= 1'b0;
      ch_l        <= '0;
      post_l      <= '0;
    end else begin
      state  <= state_d;
      run_q  <= i_run;
      stop_q <= i_stop;
      if (start) begin
        mode_l    <= i_mode;
        ch_l      <= (32'(i_ch_sel) < N_CH) ? i_ch_sel : '0;
        post_l    <= i_post_cnt;
        wr_addr   <= '0;
        post_ctr  <= '0;
        o_wrapped <= 1'b0;
      end else if (we) begin
        wr_addr     <= wr_addr + NB_ADDR'(1);
        o_last_addr <= wr_addr;
        if (mode_l & at_max) o_wrapped <= 1'b1;
        if (state == POST) post_ctr <= post_ctr + NB_ADDR'(1);
      end
    end
  end
  always_ff @(posedge clock)
    for (int c = 0; c < N_CH; c++)
      cnt[c] <= cpu_reset ? '0 : cnt[c] + incr(i_step_enb[c*NB_ENB_STEP +: NB_ENB_STEP]);
  // RAM has no reset so it maps onto block memory and survives cpu_reset
  always_ff @(posedge clock)
    if (we & ~cpu_reset) mem[wr_addr] <= cnt[ch_l];
  always_ff @(posedge clock)
    o_rd_data <= cpu_reset ? '0 : mem[i_rd_addr];
endmodule

// File: tb/tb_log_capture.sv
// tb_log_capture: directed scenarios plus random traffic checked against a behavioural capture model.
module tb_log_capture;
  localparam int NB_DATA = 8, NB_ADDR = 4, N_CH = 2, NB_ENB_STEP = 4, NB_CH_SEL = 2;
  localparam int DEPTH = 16;
  logic clock = 1'b0;
  logic cpu_reset, i_run, i_stop, i_mode;
  logic [NB_CH_SEL-1:0] i_ch_sel;
  logic [NB_ADDR-1:0] i_post_cnt, i_rd_addr, o_last_addr;
  logic [N_CH*NB_ENB_STEP-1:0] i_step_enb;
  logic [NB_DATA-1:0] o_rd_data;
  logic o_busy, o_full, o_wrapped;
  int checks = 0, errors = 0;
  log_capture #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR), .N_CH(N_CH), .NB_ENB_STEP(NB_ENB_STEP), .NB_CH_SEL(NB_CH_SEL)) dut (
    .clock(clock), .cpu_reset(cpu_reset), .i_run(i_run), .i_stop(i_stop), .i_mode(i_mode),
    .i_ch_sel(i_ch_sel), .i_post_cnt(i_post_cnt), .i_step_enb(i_step_enb), .i_rd_addr(i_rd_addr),
    .o_rd_data(o_rd_data), .o_busy(o_busy), .o_full(o_full), .o_wrapped(o_wrapped), .o_last_addr(o_last_addr));
  always #5 clock = ~clock;
  // model: phase 0 idle, 1 logging, 2 post-trigger, 3 done
  int m_cnt [N_CH];
  int m_ram [DEPTH];
  bit m_known [DEPTH];
  int m_phase, m_addr, m_left, m_last, m_mode, m_ch, m_post, m_rd;
  bit m_wrap, m_rq, m_sq, m_rd_ok;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_step();
    bit re, se;
    if (cpu_reset) begin
      m_phase = 0; m_addr = 0; m_last = 0; m_wrap = 0; m_rq = 0; m_sq = 0;
      m_rd = 0; m_rd_ok = 1;
      foreach (m_cnt[c]) m_cnt[c] = 0;
      return;
    end
    re = i_run && !m_rq;
    se = i_stop && !m_sq;
    m_rd = m_ram[i_rd_addr];
    m_rd_ok = m_known[i_rd_addr];
    if (m_phase == 1 || m_phase == 2) begin
      m_ram[m_addr] = m_cnt[m_ch];
      m_known[m_addr] = 1;
      m_last = m_addr;
      if (m_phase == 1) begin
        if (m_mode == 1 && se) begin
          m_phase = (m_post == 0) ? 3 : 2;
          m_left = m_post;
        end else if (m_mode == 0 && m_addr == DEPTH - 1) m_phase = 3;
      end else begin
        m_left--;
        if (m_left == 0) m_phase = 3;
      end
      if (m_mode == 1 && m_addr == DEPTH - 1) m_wrap = 1;
      m_addr = (m_addr + 1) % DEPTH;
    end else if (re) begin
      m_phase = 1; m_mode = i_mode; m_post = i_post_cnt; m_addr = 0; m_wrap = 0;
      m_ch = (i_ch_sel < N_CH) ? i_ch_sel : 0;
    end
    for (int c = 0; c < N_CH; c++)
      for (int k = 0; k < NB_ENB_STEP; k++)
        if (i_step_enb[c*NB_ENB_STEP + k]) begin
          m_cnt[c] = (m_cnt[c] + k + 1) % 256;
          break;
        end
    m_rq = i_run;
    m_sq = i_stop;
  endtask
  task automatic step();
    model_step();
    @(posedge clock);
    #1;
    chk("busy", o_busy, m_phase == 1 || m_phase == 2);
    chk("full", o_full, m_phase == 3);
    chk("wrapped", o_wrapped, m_wrap);
    chk("last_addr", o_last_addr, m_last);
    if (m_rd_ok) chk("rd_data", o_rd_data, m_rd);
  endtask
  task automatic steps(int n);
    for (int i = 0; i < n; i++) step();
  endtask
  task automatic wait_full(int budget);
    int n = 0;
    while (!o_full && n < budget) begin step(); n++; end
    chk("done_in_budget", o_full, 1);
  endtask
  task automatic pulse_run();
    i_run = 1; step(); i_run = 0;
  endtask
  int v0, edge_addr;
  initial begin
    cpu_reset = 1; i_run = 0; i_stop = 0; i_mode = 0; i_ch_sel = 0; i_post_cnt = 0;
    i_step_enb = 8'h01; i_rd_addr = 0;
    step();
    chk("reset_busy", o_busy, 0);
    chk("reset_rd", o_rd_data, 0);
    cpu_reset = 0;
    // one-shot fill, channel 0 stepping by 1
    pulse_run();
    wait_full(30);
    chk("s1_last", o_last_addr, 15);
    chk("s1_wrapped", o_wrapped, 0);
    i_rd_addr = 0; step(); v0 = o_rd_data;
    i_rd_addr = 1; step();
    chk("s1_consecutive", o_rd_data, (v0 + 1) % 256);
    // circular, channel 1 stepping by 3, trigger after 20 cycles
    i_step_enb = 8'h41; i_mode = 1; i_ch_sel = 1; i_post_cnt = 3;
    pulse_run();
    steps(20);
    edge_addr = m_addr;
    i_stop = 1;
    wait_full(20);
    i_stop = 0;
    chk("s2_wrapped", o_wrapped, 1);
    chk("s2_last", o_last_addr, (edge_addr + 3) % 16);
    i_rd_addr = 4'(edge_addr); step(); v0 = o_rd_data;
    i_rd_addr = 4'(edge_addr + 1); step();
    chk("s2_step3", o_rd_data, (v0 + 3) % 256);
    // lowest set enable bit wins, then all enables off
    i_step_enb = 8'h0A; i_mode = 0; i_ch_sel = 0;
    pulse_run();
    wait_full(30);
    i_rd_addr = 5; step(); v0 = o_rd_data;
    i_rd_addr = 6; step();
    chk("s3_step2", o_rd_data, (v0 + 2) % 256);
    i_step_enb = 8'h00;
    i_ch_sel = 3;
    pulse_run();
    wait_full(30);
    i_rd_addr = 2; step(); v0 = o_rd_data;
    i_rd_addr = 9; step();
    chk("s3_hold", o_rd_data, v0);
    // run held high for 40 cycles gives one capture, then restart from DONE
    i_step_enb = 8'h21; i_ch_sel = 0;
    i_run = 1; steps(40); i_run = 0;
    chk("s4_full", o_full, 1);
    step();
    pulse_run();
    chk("s4_restart_busy", o_busy, 1);
    chk("s4_restart_full", o_full, 0);
    step();
    chk("s4_restart_addr", o_last_addr, 0);
    wait_full(30);
    // reset during post-trigger phase
    i_mode = 1; i_post_cnt = 5;
    pulse_run();
    steps(20);
    i_stop = 1; step(); i_stop = 0; step();
    chk("s5_in_post", o_busy, 1);
    cpu_reset = 1; step();
    chk("s5_busy", o_busy, 0);
    chk("s5_full", o_full, 0);
    chk("s5_wrapped", o_wrapped, 0);
    chk("s5_last", o_last_addr, 0);
    chk("s5_rd", o_rd_data, 0);
    cpu_reset = 0;
    i_rd_addr = 3; v0 = m_ram[3]; step();
    chk("s5_ram_kept", o_rd_data, v0);
    // post count zero with simultaneous run and stop edges
    i_post_cnt = 0;
    pulse_run();
    steps(5);
    edge_addr = m_addr;
    i_run = 1; i_stop = 1; step();
    chk("s6_done", o_full, 1);
    chk("s6_last", o_last_addr, edge_addr);
    i_run = 0; i_stop = 0;
    step();
    chk("s6_no_more_writes", o_last_addr, edge_addr);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      cpu_reset = ($urandom_range(0, 199) == 0);
      i_run = ($urandom_range(0, 19) == 0);
      i_stop = ($urandom_range(0, 14) == 0);
      i_mode = 1'($urandom);
      i_ch_sel = 2'($urandom);
      i_post_cnt = 4'($urandom_range(0, 6));
      i_step_enb = 8'($urandom);
      i_rd_addr = 4'($urandom);
      step();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
